pc_sequencer: RTL and testbench

Program-counter sequencer for the MUSA fetch stage. It generates the 13-bit fetch PC and is the initiator side of the return-address stack interface. On a call it pushes the return address with `writeStack`. On a return it pops with `readStack` and reloads the PC from `stackOut`. Stack overflow and underflow are turned into a sticky fault that redirects fetch to a fault vector.

---
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Return-address stack link between the fetch PC sequencer (master) and the
// stack storage (slave).
//
// Signals
//   writeStack    master -> slave  push strobe, one cycle per accepted call
//   readStack     master -> slave  pop strobe, one cycle per accepted return
//   stack_pc      master -> slave  push data (return address, pc+1)
//   stackOut      slave  -> master top-of-stack data, registered on the stack side
//   stackOverflow slave  -> master stack error (overflow or underflow)
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 13
);
    logic                writeStack;
    logic                readStack;
    logic [PC_WIDTH-1:0] stack_pc;
    logic [PC_WIDTH-1:0] stackOut;
    logic                stackOverflow;

    modport master (
        output writeStack,
        output readStack,
        output stack_pc,
        input  stackOut,
        input  stackOverflow
    );

    modport slave (
        input  writeStack,
        input  readStack,
        input  stack_pc,
        output stackOut,
        output stackOverflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch program-counter sequencer for the MUSA fetch stage. Generates the fetch
// PC, pushes return addresses on calls, pops and reloads on returns, and turns
// stack errors into a sticky fault that redirects fetch to FAULT_VECTOR.
//
// Build option
//   PC_STACK_GUARD_EN  when defined, a local depth counter catches a call on a
//                      full stack or a return on an empty stack and faults
//                      without issuing the strobe.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   stall          in   hold pc and suppress requests in RUN
//   branch_en      in   load branch_target
//   branch_target  in   branch destination
//   call_en        in   push pc+1 and load call_target
//   call_target    in   call destination
//   ret_en         in   pop and reload pc from the stack
//   fault_clear    in   leave FAULT, restart at RESET_VECTOR
//   stk            if   return-address stack link (master side)
//   pc             out  current fetch address
//   pc_valid       out  pc is a valid fetch address this cycle
//   fault          out  high while in FAULT
//
// All outputs are registered.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_RUN    | normal sequencing
// ST_RET_WAIT | pop issued, reload pc from stackOut next edge
// ST_FAULT  | sticky error hold at FAULT_VECTOR
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 13,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h0000,
    parameter logic [PC_WIDTH-1:0] FAULT_VECTOR = 13'h1FFF,
    parameter int                  STACK_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_en,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                call_en,
    input  logic [PC_WIDTH-1:0] call_target,
    input  logic                ret_en,
    input  logic                fault_clear,
    pc_sequencer_if.master      stk,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic                fault
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] stack_pc_q, stack_pc_d;
    logic                pc_valid_q, pc_valid_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                fault_q, fault_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                guard_full;
    logic                guard_empty;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef PC_STACK_GUARD_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [DW-1:0] depth_q, depth_d;

    assign guard_full  = (depth_q == DW'(STACK_DEPTH));
    assign guard_empty = (depth_q == '0);
`else
    assign guard_full  = 1'b0;
    assign guard_empty = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stack_pc_d = stack_pc_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
`ifdef PC_STACK_GUARD_EN
        depth_d    = depth_q;
`endif

        case (state_q)
            ST_RUN: begin
                // Stack error outranks stall and every request.
                if (stk.stackOverflow) begin
                    state_d = ST_FAULT;
                    pc_d    = FAULT_VECTOR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (ret_en) begin
                    if (guard_empty) begin
                        state_d = ST_FAULT;
                        pc_d    = FAULT_VECTOR;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = ST_RET_WAIT;
`ifdef PC_STACK_GUARD_EN
                        depth_d = depth_q - 1'b1;
`endif
                    end
                end else if (call_en) begin
                    if (guard_full) begin
                        state_d = ST_FAULT;
                        pc_d    = FAULT_VECTOR;
                    end else begin
                        wr_d       = 1'b1;
                        stack_pc_d = pc_inc;
                        pc_d       = call_target;
`ifdef PC_STACK_GUARD_EN
                        depth_d    = depth_q + 1'b1;
`endif
                    end
                end else if (branch_en) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_inc;
                end
            end

            // One-cycle bubble; stall is deliberately not looked at here.
            ST_RET_WAIT: begin
                if (stk.stackOverflow) begin
                    state_d = ST_FAULT;
                    pc_d    = FAULT_VECTOR;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = stk.stackOut;
                end
            end

            ST_FAULT: begin
                if (fault_clear) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_VECTOR;
`ifdef PC_STACK_GUARD_EN
                    // Restart is a fresh program context, same as reset.
                    depth_d = '0;
`endif
                end
            end

            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_VECTOR;
            end
        endcase

        pc_valid_d = (state_d == ST_RUN);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            stack_pc_q <= '0;
            pc_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stack_pc_q <= stack_pc_d;
            pc_valid_q <= pc_valid_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fault_q    <= fault_d;
        end
    end

`ifdef PC_STACK_GUARD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`endif

    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign fault          = fault_q;
    assign stk.writeStack = wr_q;
    assign stk.readStack  = rd_q;
    assign stk.stack_pc   = stack_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_en;
    logic [12:0] branch_target;
    logic        call_en;
    logic [12:0] call_target;
    logic        ret_en;
    logic        fault_clear;
    logic [12:0] pc;
    logic        pc_valid;
    logic        fault;

    int checks   = 0;
    int failures = 0;
    int wcount;

    pc_sequencer_if #(.PC_WIDTH(13)) stk_if ();

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .call_en       (call_en),
        .call_target   (call_target),
        .ret_en        (ret_en),
        .fault_clear   (fault_clear),
        .stk           (stk_if),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},       {3'b0, pc}, 16'h0000);
        check({tag, "_valid"},    {15'b0, pc_valid}, 16'h0);
        check({tag, "_ws"},       {15'b0, stk_if.writeStack}, 16'h0);
        check({tag, "_rs"},       {15'b0, stk_if.readStack}, 16'h0);
        check({tag, "_stack_pc"}, {3'b0, stk_if.stack_pc}, 16'h0000);
        check({tag, "_fault"},    {15'b0, fault}, 16'h0);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_target = '0;
        call_en = 1'b0;
        call_target = '0;
        ret_en = 1'b0;
        fault_clear = 1'b0;
        stk_if.stackOut = '0;
        stk_if.stackOverflow = 1'b0;

        // Reset and idle increment
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b1;
        step();
        check("idle1_pc", {3'b0, pc}, 16'h0001);
        check("idle1_valid", {15'b0, pc_valid}, 16'h1);
        step();
        check("idle2_pc", {3'b0, pc}, 16'h0002);
        step();
        check("idle3_pc", {3'b0, pc}, 16'h0003);
        step();
        step();
        check("idle5_pc", {3'b0, pc}, 16'h0005);

        // Call at pc=5
        call_en = 1'b1;
        call_target = 13'h0100;
        step();
        check("call_ws", {15'b0, stk_if.writeStack}, 16'h1);
        check("call_stack_pc", {3'b0, stk_if.stack_pc}, 16'h0006);
        check("call_pc", {3'b0, pc}, 16'h0100);
        call_en = 1'b0;
        step();
        check("call_ws_off", {15'b0, stk_if.writeStack}, 16'h0);
        check("call_next_pc", {3'b0, pc}, 16'h0101);

        // Return to 0x0006
        stk_if.stackOut = 13'h0006;
        ret_en = 1'b1;
        step();
        check("ret_rs", {15'b0, stk_if.readStack}, 16'h1);
        check("ret_valid0", {15'b0, pc_valid}, 16'h0);
        check("ret_hold_pc", {3'b0, pc}, 16'h0101);
        ret_en = 1'b0;
        step();
        check("ret_rs_off", {15'b0, stk_if.readStack}, 16'h0);
        check("ret_valid1", {15'b0, pc_valid}, 16'h1);
        check("ret_pc", {3'b0, pc}, 16'h0006);
        step();
        check("ret_next_pc", {3'b0, pc}, 16'h0007);

        // Call at pc=7 so the stack holds one entry for the stall test
        call_en = 1'b1;
        call_target = 13'h0200;
        step();
        check("call2_stack_pc", {3'b0, stk_if.stack_pc}, 16'h0008);
        check("call2_pc", {3'b0, pc}, 16'h0200);

        // Stall with ret and call both pending
        stall = 1'b1;
        ret_en = 1'b1;
        call_target = 13'h0300;
        step();
        check("stall1_pc", {3'b0, pc}, 16'h0200);
        check("stall1_ws", {15'b0, stk_if.writeStack}, 16'h0);
        check("stall1_rs", {15'b0, stk_if.readStack}, 16'h0);
        step();
        check("stall2_pc", {3'b0, pc}, 16'h0200);
        check("stall2_valid", {15'b0, pc_valid}, 16'h1);
        check("stall2_strobes", {14'b0, stk_if.writeStack, stk_if.readStack}, 16'h0);
        stall = 1'b0;
        step();
        check("unstall_rs", {15'b0, stk_if.readStack}, 16'h1);
        check("unstall_ws", {15'b0, stk_if.writeStack}, 16'h0);
        check("unstall_pc", {3'b0, pc}, 16'h0200);
        ret_en = 1'b0;
        call_en = 1'b0;
        stk_if.stackOut = 13'h0008;
        step();
        check("unstall_ret_pc", {3'b0, pc}, 16'h0008);

        // Nine back-to-back calls from an empty stack
        wcount = 0;
        call_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            call_target = 13'h0400 + 13'(i);
            step();
            wcount += int'(stk_if.writeStack);
            check($sformatf("call9_%0d_ws", i), {15'b0, stk_if.writeStack},
                  {15'b0, !(GUARD && i == 8)});
            check($sformatf("call9_%0d_pc", i), {3'b0, pc},
                  (GUARD && i == 8) ? 16'h1FFF : 16'h0400 + 16'(i));
            check($sformatf("call9_%0d_fault", i), {15'b0, fault},
                  {15'b0, (GUARD && i == 8)});
            if (i < 8)
                check($sformatf("call9_%0d_stack_pc", i), {3'b0, stk_if.stack_pc},
                      (i == 0) ? 16'h0009 : 16'h0400 + 16'(i));
        end
        check("call9_pulses", 16'(wcount), GUARD ? 16'd8 : 16'd9);
        call_en = 1'b0;

`ifndef PC_STACK_GUARD_EN
        stk_if.stackOverflow = 1'b1;
        step();
        check("ovf_fault", {15'b0, fault}, 16'h1);
        check("ovf_pc", {3'b0, pc}, 16'h1FFF);
        stk_if.stackOverflow = 1'b0;
`endif

        // FAULT ignores requests, then clears
        call_en = 1'b1;
        ret_en = 1'b1;
        step();
        check("fault_hold_pc", {3'b0, pc}, 16'h1FFF);
        check("fault_hold_flag", {15'b0, fault}, 16'h1);
        check("fault_hold_valid", {15'b0, pc_valid}, 16'h0);
        check("fault_hold_strobes", {14'b0, stk_if.writeStack, stk_if.readStack}, 16'h0);
        call_en = 1'b0;
        ret_en = 1'b0;
        fault_clear = 1'b1;
        step();
        check("clear_pc", {3'b0, pc}, 16'h0000);
        check("clear_fault", {15'b0, fault}, 16'h0);
        check("clear_valid", {15'b0, pc_valid}, 16'h1);
        fault_clear = 1'b0;

        // Increment wrap
        branch_en = 1'b1;
        branch_target = 13'h1FFF;
        step();
        check("branch_pc", {3'b0, pc}, 16'h1FFF);
        check("branch_valid", {15'b0, pc_valid}, 16'h1);
        branch_en = 1'b0;
        step();
        check("wrap_pc", {3'b0, pc}, 16'h0000);

        // Call at 0x1FFF: push data wraps; call beats branch
        branch_en = 1'b1;
        step();
        branch_target = 13'h0077;
        call_en = 1'b1;
        call_target = 13'h0050;
        step();
        check("wcall_ws", {15'b0, stk_if.writeStack}, 16'h1);
        check("wcall_stack_pc", {3'b0, stk_if.stack_pc}, 16'h0000);
        check("wcall_pc", {3'b0, pc}, 16'h0050);
        branch_en = 1'b0;
        call_en = 1'b0;
        step();
        check("wcall_next_pc", {3'b0, pc}, 16'h0051);

        // Pop answered with a stack error during RET_WAIT
        ret_en = 1'b1;
        step();
        check("eret_rs", {15'b0, stk_if.readStack}, 16'h1);
        ret_en = 1'b0;
        stk_if.stackOverflow = 1'b1;
        step();
        check("eret_fault", {15'b0, fault}, 16'h1);
        check("eret_pc", {3'b0, pc}, 16'h1FFF);
        check("eret_rs_off", {15'b0, stk_if.readStack}, 16'h0);
        check("eret_valid", {15'b0, pc_valid}, 16'h0);
        stk_if.stackOverflow = 1'b0;
        step();
        check("eret_sticky", {15'b0, fault}, 16'h1);

        // Asynchronous reset mid-FAULT
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("arst");
        #1;
        reset = 1'b1;
        step();
        check("arst_rel_pc", {3'b0, pc}, 16'h0001);
        check("arst_rel_valid", {15'b0, pc_valid}, 16'h1);
        check("arst_rel_fault", {15'b0, fault}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
